tpu_layer_sequencer: RTL
========================

Name: tpu_layer_sequencer

Overview:
- Sequences one fully-connected layer through the 128-lane float16 multiply-accumulate datapath.
- Latches the input activation vector at start. For each neuron: reads that neuron's weight row from weight RAM, holds both operands stable on the datapath for a fixed settle window, then writes the 31-bit result to result RAM.
- Sits between the top-level inference controller (start/done) and the MAC datapath plus its weight and result memories.

Parameters:
- LANES, 128, number of float16 lanes per dot product.
- DW, 16, bits per lane.
- ACC_W, 31, width of datapath result.
- ADDR_W, 8, neuron index / memory address width.
- SETTLE_CYC, 4, cycles operands are held before sampling the datapath result (multicycle path for the 127-deep adder chain); legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin layer; sampled only in IDLE.
- abort  in  1  cancel an active layer.
- num_neurons  in  ADDR_W+1  neuron count, latched at start.
- x_in  in  LANES*DW  input vector, latched at start.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse when abort is taken.
- ovf_sticky  out  1  OR of datapath overflow over the current layer.
- w_rd_en  out  1  weight RAM read strobe.
- w_addr  out  ADDR_W  weight row address (= neuron index).
- w_rdata  in  LANES*DW  weight row, valid 1 cycle after w_rd_en.
- mac_a  out  LANES*DW  registered operand 1 (latched x).
- mac_b  out  LANES*DW  registered operand 2 (weight row).
- mac_result  in  ACC_W  datapath sum.
- mac_overflow  in  1  datapath overflow.
- res_we  out  1  result write strobe.
- res_addr  out  ADDR_W  result address.
- res_data  out  ACC_W  result value.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, aborted, w_rd_en, res_we, ovf_sticky = 0; counters, w_addr, res_addr, res_data, mac_a, mac_b = 0. No write is issued for a neuron in progress.
- States: IDLE, READ, LOAD, SETTLE, WRITE, DONE.
- IDLE:
  - start=1 and num_neurons>0: latch x_in into mac_a, latch num_neurons, idx=0, clear ovf_sticky, go to READ.
  - start=1 and num_neurons=0: clear ovf_sticky, go to DONE. No reads, no writes.
- READ: w_rd_en=1, w_addr=idx, 1 cycle, then LOAD.
- LOAD: mac_b <= w_rdata; settle counter=0; then SETTLE.
- SETTLE: hold mac_a/mac_b unchanged; count to SETTLE_CYC-1, then WRITE.
- WRITE (1 cycle):
  - res_we=1, res_addr=idx, res_data=mac_result; ovf_sticky |= mac_overflow.
  - idx==num-1: go to DONE. Otherwise idx+1, go to READ.
- DONE: done=1 for 1 cycle, then IDLE. ovf_sticky holds until the next start.
- Per-neuron cost is SETTLE_CYC+3 cycles. Start-edge to done-high latency is N*(SETTLE_CYC+3)+1 cycles (N=0: 1 cycle).
- res_data/res_addr are combinational from registers, valid only while res_we=1.
- abort in READ/LOAD/SETTLE/WRITE:
  - Next state IDLE, aborted=1 for that transition cycle, no done.
  - If abort coincides with WRITE, that write still occurs and no later write occurs.
  - abort in IDLE or DONE is ignored; DONE completes normally.
- start while busy: ignored, no re-latch.
- start and abort together in IDLE: start wins.
- num_neurons max 2^ADDR_W; idx never wraps, because termination is on idx==num-1.
- mac_a/mac_b change only in IDLE (start) and LOAD, guaranteeing the multicycle hold.

Decomposition:
- Shared package tpu_pkg: LANES, DW, ACC_W, ADDR_W, state encoding constants (IDLE..DONE), SETTLE_CYC default.
- One natural sub-module: tpu_settle_timer (load/count/expire counter, 4-bit).
- The FSM and operand registers stay in the top.

Test Plan:
- Bench uses a behavioural datapath model (sum of lane products, registered with SETTLE_CYC-1 delay checker) and a 1-cycle-latency weight RAM.
- N=3, SETTLE_CYC=4, weights row k = all 0x3C00 (1.0), x = all 0x4000 (2.0) -> 3 writes at addr 0,1,2 spaced 7 cycles apart; done pulses 22 cycles after start; ovf_sticky=0.
- N=0 start -> done pulses next cycle; no w_rd_en, no res_we; busy high exactly 1 cycle.
- mac_overflow forced 1 only for neuron 1 of N=4 -> ovf_sticky rises after 2nd write, stays 1 through done; cleared on next start.
- abort asserted on the 2nd SETTLE cycle of neuron 2 (N=5) -> aborted 1-cycle pulse, exactly 2 writes total, busy low next cycle, no done; subsequent start runs a full 5 neurons.
- start re-pulsed mid-layer with different num_neurons/x_in -> ignored; results match the original operands. Async rst asserted mid-SETTLE -> all outputs 0 immediately, no write.
- N=256 (ADDR_W=8) -> final write at addr 255, done follows; assertion: mac_a/mac_b stable throughout every SETTLE window.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared constants for the layer sequencer: datapath geometry, FSM state
// encodings and the settle-timer width.
package tpu_pkg;

  localparam int unsigned LANES      = 128;
  localparam int unsigned DW         = 16;
  localparam int unsigned ACC_W      = 31;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned SETTLE_CYC = 4;

  localparam int unsigned TIMER_W = 4;
  localparam int unsigned ST_W    = 3;

  localparam logic [ST_W-1:0] IDLE   = 3'd0;
  localparam logic [ST_W-1:0] READ   = 3'd1;
  localparam logic [ST_W-1:0] LOAD   = 3'd2;
  localparam logic [ST_W-1:0] SETTLE = 3'd3;
  localparam logic [ST_W-1:0] WRITE  = 3'd4;
  localparam logic [ST_W-1:0] DONE   = 3'd5;

endpackage

// File: rtl/tpu_settle_timer.sv
// Settle-window counter: cleared by load, advances while enabled, and flags
// expiry on the last cycle of a CYCLES-long window (holds there until reloaded).
module tpu_settle_timer #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);
  import tpu_pkg::*;

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign expired = (count == TIMER_W'(CYCLES - 1));

endmodule

// File: rtl/tpu_layer_sequencer.sv
// Walks one fully-connected layer neuron by neuron: fetch weight row, hold
// operands through the multicycle settle window, write the datapath result.
module tpu_layer_sequencer #(
  parameter int unsigned LANES      = tpu_pkg::LANES,
  parameter int unsigned DW         = tpu_pkg::DW,
  parameter int unsigned ACC_W      = tpu_pkg::ACC_W,
  parameter int unsigned ADDR_W     = tpu_pkg::ADDR_W,
  parameter int unsigned SETTLE_CYC = tpu_pkg::SETTLE_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W:0]       num_neurons,
  input  logic [LANES*DW-1:0]   x_in,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  ovf_sticky,
  output logic                  w_rd_en,
  output logic [ADDR_W-1:0]     w_addr,
  input  logic [LANES*DW-1:0]   w_rdata,
  output logic [LANES*DW-1:0]   mac_a,
  output logic [LANES*DW-1:0]   mac_b,
  input  logic [ACC_W-1:0]      mac_result,
  input  logic                  mac_overflow,
  output logic                  res_we,
  output logic [ADDR_W-1:0]     res_addr,
  output logic [ACC_W-1:0]      res_data
);
  import tpu_pkg::*;

  logic [ST_W-1:0]   state;
  logic [ST_W-1:0]   state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   num;
  logic              active;
  logic              take_abort;
  logic              last_neuron;
  logic              settle_done;

  assign active      = (state == READ) || (state == LOAD) ||
                       (state == SETTLE) || (state == WRITE);
  assign take_abort  = abort && active;
  // Terminating on idx == num-1 lets a full 2^ADDR_W layer finish without idx wrapping.
  assign last_neuron = ({1'b0, idx} == (num - (ADDR_W + 1)'(1)));

  tpu_settle_timer #(
    .CYCLES (SETTLE_CYC)
  ) u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (state == LOAD),
    .en      (state == SETTLE),
    .expired (settle_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_neurons != '0) ? READ : DONE;
        end
      end
      READ:   state_nxt = LOAD;
      LOAD:   state_nxt = SETTLE;
      SETTLE: begin
        if (settle_done) begin
          state_nxt = WRITE;
        end
      end
      WRITE:  state_nxt = last_neuron ? DONE : READ;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (take_abort) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operands only move on start and in LOAD so the adder chain sees them stable for the whole window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      num        <= '0;
      ovf_sticky <= 1'b0;
      mac_a      <= '0;
      mac_b      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ovf_sticky <= 1'b0;
            if (num_neurons != '0) begin
              mac_a <= x_in;
              num   <= num_neurons;
              idx   <= '0;
            end
          end
        end
        LOAD: begin
          mac_b <= w_rdata;
        end
        WRITE: begin
          ovf_sticky <= ovf_sticky | mac_overflow;
          if (!last_neuron && !take_abort) begin
            idx <= idx + ADDR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign aborted  = take_abort;
  assign w_rd_en  = (state == READ);
  assign w_addr   = idx;
  assign res_we   = (state == WRITE);
  assign res_addr = idx;
  assign res_data = res_we ? mac_result : '0;

endmodule
